// File: rtl/gcd_param_if.sv
// Go/done handshake bundle for the gcd_param coprocessor.
// The master drives operands and go; the slave returns status and results.
interface gcd_param_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic             go;
  logic [WIDTH-1:0] xin;
  logic [WIDTH-1:0] yin;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] gcd_out;
  logic [CNT_W-1:0] iter_cnt;
  logic             zero_flag;

  modport master (
    output go, xin, yin,
    input  ready, done, gcd_out, iter_cnt, zero_flag
  );

  modport slave (
    input  go, xin, yin,
    output ready, done, gcd_out, iter_cnt, zero_flag
  );
endinterface

// File: rtl/gcd_param.sv
// Iterative GCD coprocessor: subtractive Euclid (ALGO=0) or binary Stein (ALGO=1),
// one step per clock, with a saturating cycle counter and zero-operand shortcut.
module gcd_param #(
  parameter int WIDTH = 8,
  parameter int ALGO  = 0,
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        clr_n,
  gcd_param_if.slave  bus
);
  localparam int K_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [K_W-1:0]   k;
  logic [CNT_W-1:0] cnt;
  logic             ready_r;
  logic             done_r;
  logic [WIDTH-1:0] gcd_r;
  logic [CNT_W-1:0] iter_r;
  logic             zero_r;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state   <= IDLE;
      ready_r <= 1'b1;
      done_r  <= 1'b0;
      gcd_r   <= '0;
      iter_r  <= '0;
      zero_r  <= 1'b0;
      x       <= '0;
      y       <= '0;
      k       <= '0;
      cnt     <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.go) begin
            x       <= bus.xin;
            y       <= bus.yin;
            k       <= '0;
            cnt     <= '0;
            ready_r <= 1'b0;
            if ((bus.xin == '0) || (bus.yin == '0)) begin
              state  <= DONE;
              done_r <= 1'b1;
              gcd_r  <= bus.xin | bus.yin;
              iter_r <= '0;
              zero_r <= (bus.xin == '0) && (bus.yin == '0);
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          cnt <= sat_inc(cnt);
          if (x == y) begin
            state  <= DONE;
            done_r <= 1'b1;
            gcd_r  <= (ALGO == 1) ? (x << k) : x;
            iter_r <= sat_inc(cnt);
            zero_r <= 1'b0;
          end else if (ALGO == 1) begin
            // Stein: strip common twos into k, then odd-only factors, then subtract
            if (!x[0] && !y[0]) begin
              x <= x >> 1;
              y <= y >> 1;
              k <= k + K_W'(1);
            end else if (!x[0]) begin
              x <= x >> 1;
            end else if (!y[0]) begin
              y <= y >> 1;
            end else if (x > y) begin
              x <= x - y;
            end else begin
              y <= y - x;
            end
          end else begin
            if (x > y) x <= x - y;
            else       y <= y - x;
          end
        end
        DONE: begin
          state   <= IDLE;
          ready_r <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ready     = ready_r;
  assign bus.done      = done_r;
  assign bus.gcd_out   = gcd_r;
  assign bus.iter_cnt  = iter_r;
  assign bus.zero_flag = zero_r;
endmodule

// File: tb/tb_gcd_param.sv
// Directed bench for gcd_param: Euclid and Stein 8-bit instances plus a
// 16-bit Euclid instance with a 4-bit counter for saturation.
module tb_gcd_param;
  logic clk;
  logic clr_n;

  gcd_param_if #(.WIDTH(8),  .CNT_W(16)) if_e ();
  gcd_param_if #(.WIDTH(8),  .CNT_W(16)) if_s ();
  gcd_param_if #(.WIDTH(16), .CNT_W(4))  if_w ();

  gcd_param #(.WIDTH(8),  .ALGO(0), .CNT_W(16)) u_euclid (.clk(clk), .clr_n(clr_n), .bus(if_e.slave));
  gcd_param #(.WIDTH(8),  .ALGO(1), .CNT_W(16)) u_stein  (.clk(clk), .clr_n(clr_n), .bus(if_s.slave));
  gcd_param #(.WIDTH(16), .ALGO(0), .CNT_W(4))  u_sat    (.clk(clk), .clr_n(clr_n), .bus(if_w.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int sel    = 0;

  logic        m_done, m_ready, m_zero;
  logic [15:0] m_gcd, m_cnt;

  always_comb begin
    m_done  = 1'b0;
    m_ready = 1'b0;
    m_zero  = 1'b0;
    m_gcd   = '0;
    m_cnt   = '0;
    case (sel)
      0: begin
        m_done = if_e.done; m_ready = if_e.ready; m_zero = if_e.zero_flag;
        m_gcd  = 16'(if_e.gcd_out); m_cnt = if_e.iter_cnt;
      end
      1: begin
        m_done = if_s.done; m_ready = if_s.ready; m_zero = if_s.zero_flag;
        m_gcd  = 16'(if_s.gcd_out); m_cnt = if_s.iter_cnt;
      end
      default: begin
        m_done = if_w.done; m_ready = if_w.ready; m_zero = if_w.zero_flag;
        m_gcd  = if_w.gcd_out; m_cnt = 16'(if_w.iter_cnt);
      end
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_in(input int s, input logic g, input logic [15:0] a, input logic [15:0] b);
    case (s)
      0: begin if_e.go = g; if_e.xin = a[7:0]; if_e.yin = b[7:0]; end
      1: begin if_s.go = g; if_s.xin = a[7:0]; if_s.yin = b[7:0]; end
      default: begin if_w.go = g; if_w.xin = a; if_w.yin = b; end
    endcase
  endtask

  // Called at a negedge while the selected engine is idle; returns at the
  // negedge where done is seen, with lat = edges from go to that sample.
  task automatic run_op(input int s, input logic [15:0] a, input logic [15:0] b,
                        input int bound, input bit poke, output int lat);
    sel = s;
    set_in(s, 1'b1, a, b);
    @(negedge clk);
    set_in(s, 1'b0, a, b);
    lat = 1;
    while (m_done !== 1'b1 && lat < bound) begin
      if (poke && lat == 2) set_in(s, 1'b1, 16'd12, 16'd18);
      else                  set_in(s, 1'b0, a, b);
      @(negedge clk);
      lat++;
    end
    set_in(s, 1'b0, a, b);
    check("done_seen", {31'd0, m_done}, 32'd1);
  endtask

  int lat;
  int seen;

  initial begin
    set_in(0, 1'b0, 16'd0, 16'd0);
    set_in(1, 1'b0, 16'd0, 16'd0);
    set_in(2, 1'b0, 16'd0, 16'd0);
    clr_n = 1'b0;
    repeat (2) @(negedge clk);

    sel = 0;
    #1;
    check("rst_ready", {31'd0, m_ready}, 32'd1);
    check("rst_done",  {31'd0, m_done},  32'd0);
    check("rst_gcd",   {16'd0, m_gcd},   32'd0);
    check("rst_cnt",   {16'd0, m_cnt},   32'd0);
    check("rst_zero",  {31'd0, m_zero},  32'd0);
    @(negedge clk);
    clr_n = 1'b1;
    @(negedge clk);

    run_op(0, 16'd3, 16'd6, 50, 1'b0, lat);
    check("e36_lat",  lat, 32'd3);
    check("e36_gcd",  {16'd0, m_gcd}, 32'd3);
    check("e36_cnt",  {16'd0, m_cnt}, 32'd2);
    check("e36_zero", {31'd0, m_zero}, 32'd0);
    @(negedge clk);

    // go pulsed during CALC is ignored
    run_op(0, 16'd49, 16'd35, 50, 1'b1, lat);
    check("e4935_lat",   lat, 32'd6);
    check("e4935_gcd",   {16'd0, m_gcd}, 32'd7);
    check("e4935_cnt",   {16'd0, m_cnt}, 32'd5);
    check("done_ready0", {31'd0, m_ready}, 32'd0);

    // go during DONE is ignored and not queued
    set_in(0, 1'b1, 16'd12, 16'd18);
    @(negedge clk);
    set_in(0, 1'b0, 16'd12, 16'd18);
    check("idle_ready1", {31'd0, m_ready}, 32'd1);
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (m_done === 1'b1 || m_ready !== 1'b1) seen++;
    end
    check("no_queue", seen, 32'd0);
    check("held_gcd", {16'd0, m_gcd}, 32'd7);

    run_op(0, 16'd12, 16'd18, 50, 1'b0, lat);
    check("e1218_gcd", {16'd0, m_gcd}, 32'd6);
    check("e1218_cnt", {16'd0, m_cnt}, 32'd3);

    // back-to-back: go in the first IDLE cycle after done
    @(negedge clk);
    check("b2b_ready", {31'd0, m_ready}, 32'd1);
    run_op(0, 16'd0, 16'd20, 50, 1'b0, lat);
    check("z020_lat",  lat, 32'd1);
    check("z020_gcd",  {16'd0, m_gcd}, 32'd20);
    check("z020_cnt",  {16'd0, m_cnt}, 32'd0);
    check("z020_zero", {31'd0, m_zero}, 32'd0);
    @(negedge clk);

    // asynchronous reset in the middle of a long computation
    set_in(0, 1'b1, 16'd255, 16'd1);
    @(negedge clk);
    set_in(0, 1'b0, 16'd255, 16'd1);
    repeat (4) @(negedge clk);
    check("calc_ready0", {31'd0, m_ready}, 32'd0);
    #2;
    clr_n = 1'b0;
    #1;
    check("arst_ready", {31'd0, m_ready}, 32'd1);
    check("arst_done",  {31'd0, m_done},  32'd0);
    check("arst_gcd",   {16'd0, m_gcd},   32'd0);
    check("arst_cnt",   {16'd0, m_cnt},   32'd0);
    @(negedge clk);
    clr_n = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (m_done === 1'b1) seen++;
    end
    check("arst_nodone", seen, 32'd0);

    run_op(0, 16'd12, 16'd18, 50, 1'b0, lat);
    check("post_gcd", {16'd0, m_gcd}, 32'd6);
    check("post_cnt", {16'd0, m_cnt}, 32'd3);
    @(negedge clk);

    run_op(0, 16'd0, 16'd0, 50, 1'b0, lat);
    check("z00_gcd",  {16'd0, m_gcd}, 32'd0);
    check("z00_zero", {31'd0, m_zero}, 32'd1);
    @(negedge clk);

    run_op(1, 16'd49, 16'd35, 50, 1'b0, lat);
    check("s4935_lat", lat, 32'd7);
    check("s4935_gcd", {16'd0, m_gcd}, 32'd7);
    check("s4935_cnt", {16'd0, m_cnt}, 32'd6);
    @(negedge clk);

    run_op(1, 16'd12, 16'd18, 50, 1'b0, lat);
    check("s1218_gcd",  {16'd0, m_gcd}, 32'd6);
    check("s1218_cnt",  {16'd0, m_cnt}, 32'd5);
    check("s1218_zero", {31'd0, m_zero}, 32'd0);
    @(negedge clk);

    // 65534 subtractions + equality cycle overflow a 4-bit counter
    run_op(2, 16'd65535, 16'd1, 70000, 1'b0, lat);
    check("sat_lat", lat, 32'd65536);
    check("sat_gcd", {16'd0, m_gcd}, 32'd1);
    check("sat_cnt", {16'd0, m_cnt}, 32'd15);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/gcd_param.md
Name: gcd_param

Overview:
- Parametrised, handshaked successor to the team's 8-bit GCD engine.
- Computes gcd(xin, yin) for unsigned WIDTH-bit operands.
- Algorithm is selectable at elaboration:
  - ALGO=0: subtractive Euclid.
  - ALGO=1: binary Stein.
- Adds ready/done handshake, explicit zero-operand handling and a saturating iteration counter. Sits as a standalone arithmetic coprocessor behind a simple go/done control interface.

Parameters:
WIDTH, 8, operand and result width in bits (>=2)
ALGO, 0, 0 = subtractive Euclid, 1 = binary Stein (shift/subtract)
CNT_W, 16, width of the iteration counter output

Ports:
clk  input  1  system clock, rising-edge active
clr_n  input  1  asynchronous active-low reset
go  input  1  start request, sampled on rising clk when ready=1
xin  input  WIDTH  operand X, captured with go
yin  input  WIDTH  operand Y, captured with go
ready  output  1  high in IDLE; engine accepts go
done  output  1  one-cycle pulse: gcd_out/iter_cnt/zero_flag just updated
gcd_out  output  WIDTH  last result, held until next completion
iter_cnt  output  CNT_W  CALC cycles used by the last operation, saturating
zero_flag  output  1  last operation had xin==0 and yin==0

Behaviour:
- Reset (clr_n=0, asynchronous, any state):
  - State goes to IDLE.
  - ready=1, done=0, gcd_out=0, iter_cnt=0, zero_flag=0.
  - Internal x, y, k and counter are cleared.
  - Reset mid-operation discards the computation; no done is produced.
- States: IDLE, CALC, DONE.
- IDLE:
  - ready=1.
  - go=1 at an edge captures xin->x and yin->y, clears k and the counter, and sets ready=0.
  - If xin==0 or yin==0, the next state is DONE with result = xin|yin, count 0, and zero_flag = (both zero).
  - Otherwise the next state is CALC.
- CALC: exactly one operation per clock.
  - If x==y: result = x<<k (ALGO=1) or x (ALGO=0); next state is DONE.
  - ALGO=0, otherwise: if x>y then x<=x-y, else y<=y-x.
  - ALGO=1, otherwise, first matching rule applies:
    - both even: x>>=1, y>>=1, k++;
    - x even: x>>=1;
    - y even: y>>=1;
    - else larger <= larger-smaller.
  - The counter increments once per CALC cycle, including the terminating equality cycle, and saturates at 2^CNT_W-1.
- DONE (one cycle):
  - gcd_out, iter_cnt and zero_flag are registered on entry.
  - done=1 for exactly this cycle; ready=0.
  - Next state is IDLE unconditionally.
- Timing and handshake:
  - go is ignored while ready=0, including during DONE; it is not queued.
  - Latency from the go edge to the done pulse is iter_cnt+1 cycles (zero-operand case: 1 cycle).
  - Back-to-back operation: go may be asserted in the first IDLE cycle after done.
- Width rules:
  - All arithmetic is unsigned WIDTH-bit. Subtraction never underflows, because the larger operand is the minuend.
  - k is clog2(WIDTH)+1 bits.
  - Stein shift-back never overflows, since the true gcd is at most max(xin, yin).
- gcd_out is stable between done pulses. xin and yin are don't-care after the capture edge.

Test Plan:
- Reset, then go with xin=3, yin=6 (ALGO=0) -> done pulse 3 cycles after the go edge; gcd_out=3, iter_cnt=2, zero_flag=0.
- xin=49, yin=35:
  - ALGO=0 -> gcd_out=7, iter_cnt=5.
  - ALGO=1 -> gcd_out=7, iter_cnt=6.
- ALGO=1, xin=12, yin=18 -> gcd_out=6, iter_cnt=5 (k=1 restores the factor 2). ALGO=0 on the same inputs -> gcd_out=6, iter_cnt=3.
- Zero operands:
  - xin=0, yin=20 -> done on the cycle after go; gcd_out=20, iter_cnt=0, zero_flag=0.
  - xin=0, yin=0 -> gcd_out=0, zero_flag=1.
- Handshake:
  - Pulse go with new operands while busy -> ignored; the result matches the first operands.
  - Assert go right after done -> second result correct; ready timing as specified.
- Reset and saturation:
  - Assert clr_n=0 mid-CALC -> all outputs return to reset values immediately; no done. A subsequent go computes correctly.
  - WIDTH=16, CNT_W=4, ALGO=0, xin=65535, yin=1 -> gcd_out=1, iter_cnt=15 (saturated).
